school_mips_top: RTL and testbench
==================================

# school_mips_top

Top level of a single-cycle, 32-bit MIPS-subset teaching processor: a clock divider, a 64-word instruction ROM, a 32×32 register file and a single-cycle datapath. A debug read port exposes any register for boards and benches. Benches observe the CPU-internal signals `instr`, `pc` and the register array `rf` on each rising `cpu_clk` edge.

## Interface
- `DIV_SHIFT`, 16 — fixed extra divider shift; `cpu_clk` tap = counter bit `DIV_SHIFT + clk_devide`.
- `DIV_BYPASS`, 0 — when 1, `cpu_clk = clk` (divider bypassed; used in simulation).
- `ROM_WORDS`, 64 — instruction ROM depth; loadable by `$readmemh` of a hex image.
- `clk` — input, 1 bit, board clock.
- `rst_n` — input, 1 bit, reset; asynchronous, active-high.
- `clk_devide` — input, 4 bits, divider select.
- `clk_enable` — input, 1 bit, divider counter enable.
- `cpu_clk` — output, 1 bit, processor clock.
- `reg_addr` — input, 5 bits, debug register select.
- `reg_data` — output, 32 bits, debug register value (combinational).

## Operation
- **Divider:** free-running counter advances on `clk` while `clk_enable` = 1; holds otherwise.
- **Fetch:** `instr = rom[pc[7:2]]`. `pc` advances by 4 each `cpu_clk`.
- **Register file:**
  - `r0` reads 0; writes to it are ignored.
  - Two combinational read ports (`rs`, `rt`) and a third debug port (`reg_addr` → `reg_data`).
  - One write port, written on the rising edge of `cpu_clk`.
- **R-type (opcode 0),** write `rd`:
  - addu (funct 0x21): `rs + rt`.
  - or (0x25): `rs | rt`.
  - srl (0x02): `rt >> shamt`, logical.
  - sltu (0x2B): unsigned `rs < rt` → 1 : 0.
  - subu (0x23): `rs − rt`.
- **I-type,** write `rt`:
  - addiu (0x09): `rs + sext(imm)`.
  - lui (0x0F): `{imm, 16'h0}`.
- **Branches:**
  - beq (0x04): taken if `rs == rt`.
  - bne (0x05): taken if `rs != rt`.
  - Taken target = `pc + 4 + (sext(imm) << 2)`; no delay slot.
- Any other opcode or funct: no write, `pc + 4`.
- Arithmetic is modulo 2^32; no overflow traps.

## Timing
- Reset (`rst_n` = 1):
  - Asynchronously clears `pc` to 0, the divider counter to 0 and all registers to 0.
  - `cpu_clk` is 0 in divided mode and follows `clk` in bypass.
  - `reg_data` reads 0.
- Single cycle:
  - Each instruction completes on one rising `cpu_clk` edge.
  - The result is visible on `reg_data` immediately after that edge.
- First edge after reset release executes `rom[0]`.
- `pc` wraps modulo 2^32; ROM index wraps modulo `ROM_WORDS`.
- Reset asserted mid-program: state is cleared immediately; execution restarts from `pc` = 0 on release.
- Divided mode: `cpu_clk` period = 2^(`DIV_SHIFT` + `clk_devide` + 1) `clk` periods.

## Structure
- Shared package `sm_pkg`: opcode and funct constants, ALU operation enum.
- Sub-modules:
  - `sm_clk_divider`
  - `sm_rom` (instance `reset_rom`, array `rom`)
  - `sm_cpu` (exposes `pc`, `instr` and register file instance `rf` with array `rf`)
  - `sm_register_file` inside `sm_cpu`

## Test plan
- ROM `addiu $1,$0,5`; `addiu $2,$0,3`; `addu $3,$1,$2` → `r3` = 8, `pc` = 12 after 3 edges.
- `subu $4,$2,$1` → `r4` = 0xFFFFFFFE; `sltu $5,$2,$1` → 1; `srl $6,$1,1` → 2; `or` → 7.
- `lui $7,0x1234` → `r7` = 0x12340000; `addiu $0,$0,9` → `r0` stays 0.
- `bne $1,$0,-1` loops: `pc` stays constant; `beq` with unequal operands falls through to `pc + 4`.
- Reset pulse mid-run → `pc` = 0 and all `reg_data` = 0 immediately; first post-release edge re-executes `rom[0]`.
- `DIV_BYPASS` = 0, `DIV_SHIFT` = 0, `clk_devide` = 1 → `cpu_clk` period = 4 `clk` periods; `clk_enable` = 0 freezes `cpu_clk`.

Source files
------------

// File: rtl/sm_pkg.sv
// Shared constants for the school MIPS subset: opcodes, R-type function codes
// and the ALU operation encoding used by the datapath decoder.
package sm_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_OR,
        ALU_SRL,
        ALU_SLTU,
        ALU_LUI
    } aluOp_t;

    function automatic logic [31:0] signExtend(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/school_mips_if.sv
// Board-facing bundle of the teaching CPU: divider control, the processor
// clock and the debug register read port.
interface school_mips_if;

    logic [3:0]  clk_devide;
    logic        clk_enable;
    logic        cpu_clk;
    logic [4:0]  reg_addr;
    logic [31:0] reg_data;

    modport master (
        output clk_devide,
        output clk_enable,
        output reg_addr,
        input  cpu_clk,
        input  reg_data
    );

    modport slave (
        input  clk_devide,
        input  clk_enable,
        input  reg_addr,
        output cpu_clk,
        output reg_data
    );

endinterface

// File: rtl/sm_clk_divider.sv
// Free-running counter divider; cpu_clk is one selectable counter bit, or the
// board clock itself when the divider is bypassed for simulation.
module sm_clk_divider #(
    parameter int DIV_SHIFT  = 16,
    parameter int DIV_BYPASS = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] clk_devide,
    input  logic       clk_enable,
    output logic       cpu_clk
);

    localparam int CNT_W = DIV_SHIFT + 16;

    logic [CNT_W-1:0] count;
    logic             tapBit;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n)
            count <= '0;
        else if (clk_enable)
            count <= count + CNT_W'(1);
    end

    // Explicit mux over the 16 legal taps keeps the index in range for any DIV_SHIFT.
    always_comb begin
        tapBit = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (clk_devide == 4'(i))
                tapBit = count[DIV_SHIFT + i];
        end
    end

    assign cpu_clk = (DIV_BYPASS != 0) ? clk : tapBit;

endmodule

// File: rtl/sm_cpu.sv
// Single-cycle datapath: decode, ALU, branch resolution and the program
// counter; every instruction retires on one rising clk edge.
module sm_cpu
    import sm_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    output logic [29:0] romAddr,
    input  logic [4:0]  regAddr,
    output logic [31:0] regData
);

    logic [31:0] pc;
    logic [31:0] pcPlus4;
    logic [31:0] pcNext;

    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [31:0] sextImm;

    logic [31:0] rsVal;
    logic [31:0] rtVal;
    logic [31:0] srcB;
    logic [31:0] aluResult;

    logic        regWe;
    logic [4:0]  wAddr;
    aluOp_t      aluOp;
    logic        useImm;
    logic        takeBranch;

    assign opcode  = instr[31:26];
    assign rs      = instr[25:21];
    assign rt      = instr[20:16];
    assign rd      = instr[15:11];
    assign shamt   = instr[10:6];
    assign funct   = instr[5:0];
    assign imm     = instr[15:0];
    assign sextImm = signExtend(imm);

    sm_register_file rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .rsAddr  (rs),
        .rtAddr  (rt),
        .dbgAddr (regAddr),
        .rsData  (rsVal),
        .rtData  (rtVal),
        .dbgData (regData),
        .we      (regWe),
        .wAddr   (wAddr),
        .wData   (aluResult)
    );

    // Unsupported opcodes and functs fall out as no-write, sequential pc.
    always_comb begin
        regWe      = 1'b0;
        wAddr      = rd;
        aluOp      = ALU_ADD;
        useImm     = 1'b0;
        takeBranch = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: begin regWe = 1'b1; aluOp = ALU_ADD;  end
                    FN_SUBU: begin regWe = 1'b1; aluOp = ALU_SUB;  end
                    FN_OR:   begin regWe = 1'b1; aluOp = ALU_OR;   end
                    FN_SRL:  begin regWe = 1'b1; aluOp = ALU_SRL;  end
                    FN_SLTU: begin regWe = 1'b1; aluOp = ALU_SLTU; end
                    default: regWe = 1'b0;
                endcase
            end
            OP_ADDIU: begin
                regWe  = 1'b1;
                wAddr  = rt;
                useImm = 1'b1;
                aluOp  = ALU_ADD;
            end
            OP_LUI: begin
                regWe = 1'b1;
                wAddr = rt;
                aluOp = ALU_LUI;
            end
            OP_BEQ:  takeBranch = (rsVal == rtVal);
            OP_BNE:  takeBranch = (rsVal != rtVal);
            default: regWe = 1'b0;
        endcase
    end

    assign srcB = useImm ? sextImm : rtVal;

    always_comb begin
        case (aluOp)
            ALU_ADD:  aluResult = rsVal + srcB;
            ALU_SUB:  aluResult = rsVal - srcB;
            ALU_OR:   aluResult = rsVal | srcB;
            ALU_SRL:  aluResult = srcB >> shamt;
            ALU_SLTU: aluResult = {31'd0, (rsVal < srcB)};
            ALU_LUI:  aluResult = {imm, 16'h0000};
            default:  aluResult = rsVal + srcB;
        endcase
    end

    assign pcPlus4 = pc + 32'd4;
    assign pcNext  = takeBranch ? (pcPlus4 + {sextImm[29:0], 2'b00}) : pcPlus4;
    assign romAddr = pc[31:2];

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n)
            pc <= '0;
        else
            pc <= pcNext;
    end

endmodule

// File: rtl/sm_register_file.sv
// 32x32 register file: two operand read ports, one debug read port and one
// write port. r0 is hard-wired to zero.
module sm_register_file (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rsAddr,
    input  logic [4:0]  rtAddr,
    input  logic [4:0]  dbgAddr,
    output logic [31:0] rsData,
    output logic [31:0] rtData,
    output logic [31:0] dbgData,
    input  logic        we,
    input  logic [4:0]  wAddr,
    input  logic [31:0] wData
);

    logic [31:0] rf [32];

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < 32; i++)
                rf[i] <= '0;
        end else if (we && (wAddr != 5'd0)) begin
            rf[wAddr] <= wData;
        end
    end

    assign rsData  = (rsAddr  == 5'd0) ? 32'd0 : rf[rsAddr];
    assign rtData  = (rtAddr  == 5'd0) ? 32'd0 : rf[rtAddr];
    assign dbgData = (dbgAddr == 5'd0) ? 32'd0 : rf[dbgAddr];

endmodule

// File: rtl/sm_rom.sv
// Asynchronous-read instruction ROM; contents are loaded from a hex image.
module sm_rom #(
    parameter int WORDS = 64
) (
    input  logic [29:0] wordAddr,
    output logic [31:0] data
);

    localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;

    logic [31:0]   rom [WORDS];
    logic [AW-1:0] index;

    assign index = AW'(wordAddr % 30'(WORDS));
    assign data  = rom[index];

endmodule

// File: rtl/school_mips_top.sv
// Top of the teaching processor: clock divider, instruction ROM and the
// single-cycle CPU, with a debug register read port on the board bundle.
module school_mips_top #(
    parameter int DIV_SHIFT  = 16,
    parameter int DIV_BYPASS = 0,
    parameter int ROM_WORDS  = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    school_mips_if.slave bus
);

    logic        cpuClk;
    logic [29:0] romAddr;
    logic [31:0] instr;

    sm_clk_divider #(
        .DIV_SHIFT  (DIV_SHIFT),
        .DIV_BYPASS (DIV_BYPASS)
    ) divider (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_devide (bus.clk_devide),
        .clk_enable (bus.clk_enable),
        .cpu_clk    (cpuClk)
    );

    assign bus.cpu_clk = cpuClk;

    sm_rom #(
        .WORDS (ROM_WORDS)
    ) reset_rom (
        .wordAddr (romAddr),
        .data     (instr)
    );

    sm_cpu cpu (
        .clk     (cpuClk),
        .rst_n   (rst_n),
        .instr   (instr),
        .romAddr (romAddr),
        .regAddr (bus.reg_addr),
        .regData (bus.reg_data)
    );

endmodule

// File: tb/tb_school_mips_top.sv
// Scoreboard bench: an instruction-level model predicts pc and register
// writes per cpu edge; a second divided-mode instance checks cpu_clk timing.
module tb_school_mips_top;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    school_mips_if bus ();
    school_mips_if busDiv ();

    school_mips_top #(.DIV_SHIFT(16), .DIV_BYPASS(1), .ROM_WORDS(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    school_mips_top #(.DIV_SHIFT(0), .DIV_BYPASS(0), .ROM_WORDS(64)) dutDiv (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busDiv)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          regIdx;
        logic [31:0] value;
    } sbEntry_t;

    sbEntry_t    sbQ[$];
    logic [31:0] romImage [64];
    logic [31:0] mReg [32];
    logic [31:0] mPc;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic readReg(input int idx, output logic [31:0] val);
        bus.reg_addr = 5'(idx);
        #1;
        val = bus.reg_data;
    endtask

    task automatic modelReset();
        mPc = 32'd0;
        for (int i = 0; i < 32; i++) mReg[i] = 32'd0;
    endtask

    // Architectural model: executes the word at mPc and queues what the DUT must show.
    task automatic modelStep();
        logic [31:0] w, sImm, res, nextPc;
        logic [5:0]  op, fn;
        int          s, t, d, dst;
        bit          wr;
        sbEntry_t    e;
        w      = romImage[int'((mPc >> 2) & 32'h3F)];
        op     = w[31:26];
        fn     = w[5:0];
        s      = int'(w[25:21]);
        t      = int'(w[20:16]);
        d      = int'(w[15:11]);
        sImm   = {{16{w[15]}}, w[15:0]};
        nextPc = mPc + 32'd4;
        wr     = 1'b0;
        dst    = 0;
        res    = 32'd0;
        case (op)
            6'h00: begin
                dst = d;
                wr  = 1'b1;
                case (fn)
                    6'h21:   res = mReg[s] + mReg[t];
                    6'h23:   res = mReg[s] - mReg[t];
                    6'h25:   res = mReg[s] | mReg[t];
                    6'h02:   res = mReg[t] >> w[10:6];
                    6'h2B:   res = (mReg[s] < mReg[t]) ? 32'd1 : 32'd0;
                    default: wr = 1'b0;
                endcase
            end
            6'h09: begin dst = t; wr = 1'b1; res = mReg[s] + sImm; end
            6'h0F: begin dst = t; wr = 1'b1; res = {w[15:0], 16'h0000}; end
            6'h04: if (mReg[s] == mReg[t]) nextPc = mPc + 32'd4 + (sImm << 2);
            6'h05: if (mReg[s] != mReg[t]) nextPc = mPc + 32'd4 + (sImm << 2);
            default: wr = 1'b0;
        endcase
        if (wr && dst != 0) mReg[dst] = res;
        e.tag    = $sformatf("pc@%0h", mPc);
        e.regIdx = -1;
        e.value  = nextPc;
        sbQ.push_back(e);
        if (wr) begin
            e.tag    = $sformatf("r%0d@%0h", dst, mPc);
            e.regIdx = dst;
            e.value  = mReg[dst];
            sbQ.push_back(e);
        end
        mPc = nextPc;
    endtask

    // One cpu_clk edge in bypass mode; the scoreboard drains after the edge.
    task automatic applyStimulus();
        sbEntry_t    e;
        logic [31:0] got;
        modelStep();
        @(posedge clk);
        @(negedge clk);
        while (sbQ.size() != 0) begin
            e = sbQ.pop_front();
            if (e.regIdx < 0) got = dut.cpu.pc;
            else readReg(e.regIdx, got);
            checkOutput(e.tag, got, e.value);
        end
    endtask

    task automatic measurePeriod(output int period);
        int n;
        bit prev, cur, seen;
        period = -1;
        seen   = 1'b0;
        n      = 0;
        prev   = busDiv.cpu_clk;
        for (int i = 0; i < 400 && period < 0; i++) begin
            @(negedge clk);
            cur = busDiv.cpu_clk;
            if (seen) n++;
            if (!prev && cur) begin
                if (seen) period = n;
                else begin seen = 1'b1; n = 0; end
            end
            prev = cur;
        end
    endtask

    initial begin
        logic [31:0] v;
        int          period, toggles;
        bit          last;

        rst_n             = 1'b1;
        bus.clk_devide    = 4'd0;
        bus.clk_enable    = 1'b1;
        bus.reg_addr      = 5'd0;
        busDiv.clk_devide = 4'd1;
        busDiv.clk_enable = 1'b1;
        busDiv.reg_addr   = 5'd0;

        for (int i = 0; i < 64; i++) romImage[i] = 32'h0000_0000;
        romImage[0]  = 32'h2401_0005;  // addiu $1,$0,5
        romImage[1]  = 32'h2402_0003;  // addiu $2,$0,3
        romImage[2]  = 32'h0022_1821;  // addu  $3,$1,$2
        romImage[3]  = 32'h0041_2023;  // subu  $4,$2,$1
        romImage[4]  = 32'h0041_282B;  // sltu  $5,$2,$1
        romImage[5]  = 32'h0001_3042;  // srl   $6,$1,1
        romImage[6]  = 32'h0022_4025;  // or    $8,$1,$2
        romImage[7]  = 32'h3C07_1234;  // lui   $7,0x1234
        romImage[8]  = 32'h2400_0009;  // addiu $0,$0,9
        romImage[9]  = 32'h1022_0005;  // beq   $1,$2,+5
        romImage[10] = 32'h0022_482B;  // sltu  $9,$1,$2
        romImage[11] = 32'h1021_0001;  // beq   $1,$1,+1
        romImage[12] = 32'h240A_0077;  // addiu $10,$0,0x77
        romImage[13] = 32'h1420_FFFF;  // bne   $1,$0,-1
        for (int i = 0; i < 64; i++) begin
            dut.reset_rom.rom[i]    = romImage[i];
            dutDiv.reset_rom.rom[i] = 32'h0000_0000;
        end
        modelReset();

        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        checkOutput("bypassHi", 32'(bus.cpu_clk), 32'd1);
        checkOutput("divRstLow", 32'(busDiv.cpu_clk), 32'd0);
        @(negedge clk);
        #1;
        checkOutput("bypassLo", 32'(bus.cpu_clk), 32'd0);
        checkOutput("rstPc", dut.cpu.pc, 32'd0);
        readReg(1, v);
        checkOutput("rstR1", v, 32'd0);
        rst_n = 1'b0;

        repeat (3) applyStimulus();
        checkOutput("pcAfter3", dut.cpu.pc, 32'd12);
        readReg(3, v); checkOutput("addu_r3", v, 32'd8);

        repeat (13) applyStimulus();
        checkOutput("loopPc", dut.cpu.pc, 32'd52);
        readReg(4, v);  checkOutput("subu_r4", v, 32'hFFFF_FFFE);
        readReg(5, v);  checkOutput("sltu_r5", v, 32'd1);
        readReg(6, v);  checkOutput("srl_r6", v, 32'd2);
        readReg(8, v);  checkOutput("or_r8", v, 32'd7);
        readReg(7, v);  checkOutput("lui_r7", v, 32'h1234_0000);
        readReg(0, v);  checkOutput("r0_zero", v, 32'd0);
        readReg(9, v);  checkOutput("sltu_r9", v, 32'd0);
        readReg(10, v); checkOutput("skip_r10", v, 32'd0);
        for (int i = 0; i < 32; i++) begin
            readReg(i, v);
            checkOutput($sformatf("sweep_r%0d", i), v, mReg[i]);
        end

        @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        checkOutput("midRstPc", dut.cpu.pc, 32'd0);
        for (int i = 1; i < 32; i++) begin
            readReg(i, v);
            checkOutput($sformatf("midRst_r%0d", i), v, 32'd0);
        end
        modelReset();
        @(negedge clk);
        rst_n = 1'b0;
        applyStimulus();
        checkOutput("restartPc", dut.cpu.pc, 32'd4);
        readReg(1, v); checkOutput("restart_r1", v, 32'd5);

        for (int d = 0; d < 3; d++) begin
            busDiv.clk_devide = 4'(d);
            measurePeriod(period);
            checkOutput($sformatf("divPeriod%0d", d), 32'(period), 32'd1 << (d + 1));
        end

        busDiv.clk_devide = 4'd1;
        busDiv.clk_enable = 1'b0;
        @(negedge clk);
        last    = busDiv.cpu_clk;
        toggles = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busDiv.cpu_clk != last) toggles++;
            last = busDiv.cpu_clk;
        end
        checkOutput("freezeToggles", 32'(toggles), 32'd0);
        busDiv.clk_enable = 1'b1;
        measurePeriod(period);
        checkOutput("resumePeriod", 32'(period), 32'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
